// File: rtl/rc4.sv
// RC4 keystream generator: builds the S-box (INIT), mixes in a 1..4 byte
// key (KSA), then emits NUM_BYTES keystream bytes on ckey (PRGA).
//
// Ports:
//   clk, rst           - clock; synchronous active-high reset
//   start              - run request, only looked at in IDLE
//   key, key_length    - key bytes (byte n = key[8n+7:8n]); length 0 or >4 means 4
//   state, KSA, PRGA   - FSM encoding and phase flags
//   wen                - S-box write enable
//   i_out, j_out       - i and j registers
//   k_out              - last output index t = S[i]+S[j]
//   raddr_1, rdata_1   - S-box read port 1
//   waddr_2, wdata_2   - S-box write port 2
//   addr_3, rdata_3,
//   wdata_3            - S-box read/write port 3
//   ckey               - last keystream byte
//   done               - run complete
//
// Build option: RC4_DONE_HOLD_EN keeps done high until the next accepted
// start or reset; without it done is a one-cycle pulse.
module rc4 #(
    parameter int NUM_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] key,
    input  logic [7:0]  key_length,
    output logic [2:0]  state,
    output logic        KSA,
    output logic        PRGA,
    output logic        wen,
    output logic [7:0]  i_out,
    output logic [7:0]  j_out,
    output logic [7:0]  k_out,
    output logic [7:0]  raddr_1,
    output logic [7:0]  rdata_1,
    output logic [7:0]  waddr_2,
    output logic [7:0]  wdata_2,
    output logic [7:0]  addr_3,
    output logic [7:0]  rdata_3,
    output logic [7:0]  wdata_3,
    output logic [7:0]  ckey,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_KSA_A  = 3'd2,
        ST_KSA_B  = 3'd3,
        ST_KSA_C  = 3'd4,
        ST_PRGA_A = 3'd5,
        ST_PRGA_B = 3'd6,
        ST_PRGA_C = 3'd7
    } state_e;

    localparam logic [7:0] LAST_BYTE = 8'(NUM_BYTES - 1);

    state_e      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [31:0] key_q, key_d;
    logic [2:0]  len_q, len_d;
    logic [1:0]  kidx_q, kidx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  ckey_q, ckey_d;
    logic        done_q, done_d;

    logic [7:0]  sbox_q [256];
    logic [7:0]  rd1;
    logic [7:0]  rd3;
    logic [7:0]  kbyte;
    logic [7:0]  i_inc;
    logic [7:0]  t;
    logic        we3;

    assign rd1   = sbox_q[raddr_1];
    assign rd3   = sbox_q[addr_3];
    assign i_inc = i_q + 8'd1;
    assign t     = si_q + sj_q;

    always_comb begin
        kbyte = key_q[7:0];
        unique case (kidx_q)
            2'd0: kbyte = key_q[7:0];
            2'd1: kbyte = key_q[15:8];
            2'd2: kbyte = key_q[23:16];
            2'd3: kbyte = key_q[31:24];
        endcase
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        key_d   = key_q;
        len_d   = len_q;
        kidx_d  = kidx_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        ckey_d  = ckey_q;
`ifdef RC4_DONE_HOLD_EN
        done_d  = done_q;
`else
        done_d  = 1'b0;
`endif
        wen     = 1'b0;
        we3     = 1'b0;
        raddr_1 = 8'd0;
        waddr_2 = 8'd0;
        wdata_2 = 8'd0;
        addr_3  = 8'd0;
        wdata_3 = 8'd0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key;
                    if (key_length == 8'd0 || key_length > 8'd4)
                        len_d = 3'd4;
                    else
                        len_d = key_length[2:0];
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    kidx_d  = 2'd0;
                    cnt_d   = 8'd0;
                    done_d  = 1'b0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                wen     = 1'b1;
                waddr_2 = i_q;
                wdata_2 = i_q;
                i_d     = i_inc;
                if (i_q == 8'hFF)
                    state_d = ST_KSA_A;
            end
            ST_KSA_A: begin
                raddr_1 = i_q;
                si_d    = rd1;
                j_d     = j_q + rd1 + kbyte;
                state_d = ST_KSA_B;
            end
            ST_KSA_B: begin
                addr_3  = j_q;
                sj_d    = rd3;
                state_d = ST_KSA_C;
            end
            ST_KSA_C: begin
                // i==j reads the same entry twice, so si==sj and the
                // double write leaves S unchanged.
                wen     = 1'b1;
                we3     = 1'b1;
                waddr_2 = i_q;
                wdata_2 = sj_q;
                addr_3  = j_q;
                wdata_3 = si_q;
                i_d     = i_inc;
                if ({1'b0, kidx_q} == len_q - 3'd1)
                    kidx_d = 2'd0;
                else
                    kidx_d = kidx_q + 2'd1;
                if (i_q == 8'hFF) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    state_d = ST_PRGA_A;
                end else begin
                    state_d = ST_KSA_A;
                end
            end
            ST_PRGA_A: begin
                raddr_1 = i_inc;
                i_d     = i_inc;
                si_d    = rd1;
                j_d     = j_q + rd1;
                state_d = ST_PRGA_B;
            end
            ST_PRGA_B: begin
                addr_3  = j_q;
                sj_d    = rd3;
                state_d = ST_PRGA_C;
            end
            ST_PRGA_C: begin
                wen     = 1'b1;
                we3     = 1'b1;
                waddr_2 = i_q;
                wdata_2 = sj_q;
                addr_3  = j_q;
                wdata_3 = si_q;
                raddr_1 = t;
                k_d     = t;
                // The array still holds pre-swap values this cycle, so
                // forward the swapped entries when t hits i or j.
                if (t == i_q)
                    ckey_d = sj_q;
                else if (t == j_q)
                    ckey_d = si_q;
                else
                    ckey_d = rd1;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST_BYTE) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PRGA_A;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            key_q   <= 32'd0;
            len_q   <= 3'd4;
            kidx_q  <= 2'd0;
            cnt_q   <= 8'd0;
            k_q     <= 8'd0;
            ckey_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
            len_q   <= len_d;
            kidx_q  <= kidx_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            ckey_q  <= ckey_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wen) begin
            sbox_q[waddr_2] <= wdata_2;
            if (we3)
                sbox_q[addr_3] <= wdata_3;
        end
    end

    assign state   = state_q;
    assign KSA     = (state_q == ST_KSA_A) || (state_q == ST_KSA_B) ||
                     (state_q == ST_KSA_C);
    assign PRGA    = (state_q == ST_PRGA_A) || (state_q == ST_PRGA_B) ||
                     (state_q == ST_PRGA_C);
    assign rdata_1 = (state_q == ST_IDLE) ? 8'd0 : rd1;
    assign rdata_3 = (state_q == ST_IDLE) ? 8'd0 : rd3;
    assign i_out   = i_q;
    assign j_out   = j_q;
    assign k_out   = k_q;
    assign ckey    = ckey_q;
    assign done    = done_q;

endmodule

// File: tb/tb_rc4.sv
// Bench for rc4: directed keys, scoreboard of expected keystream bytes
// popped by a monitor whenever a byte completes.
module tb_rc4;

    localparam int NB = 10;

    typedef logic [7:0] vec_t [NB];
    typedef struct packed {
        logic       chk;
        logic [7:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] key = 32'd0;
    logic [7:0]  key_length = 8'd0;
    logic [2:0]  state;
    logic        KSA, PRGA, wen;
    logic [7:0]  i_out, j_out, k_out;
    logic [7:0]  raddr_1, rdata_1, waddr_2, wdata_2;
    logic [7:0]  addr_3, rdata_3, wdata_3, ckey;
    logic        done;

    int applied = 0;
    int miscmp  = 0;
    exp_t sb[$];
    logic [2:0] prev_st = 3'd0;

    vec_t key_exp  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                       8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    vec_t wiki_exp = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41,
                       8'hB7, 8'h00, 8'h00, 8'h00, 8'h00};
    vec_t none_exp = '{default: 8'h00};

    rc4 #(.NUM_BYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key),
        .key_length(key_length), .state(state), .KSA(KSA),
        .PRGA(PRGA), .wen(wen), .i_out(i_out), .j_out(j_out),
        .k_out(k_out), .raddr_1(raddr_1), .rdata_1(rdata_1),
        .waddr_2(waddr_2), .wdata_2(wdata_2), .addr_3(addr_3),
        .rdata_3(rdata_3), .wdata_3(wdata_3), .ckey(ckey),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // A byte is ready on ckey the cycle after PRGA_C.
    always @(negedge clk) begin
        exp_t e;
        if (prev_st == 3'd7) begin
            if (sb.size() == 0) begin
                applied++;
                miscmp++;
                $display("FAIL unexpected_byte: got %0h want none", ckey);
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    applied++;
                    if (ckey !== e.val) begin
                        miscmp++;
                        $display("FAIL ckey: got %0h want %0h", ckey, e.val);
                    end
                end
            end
        end
        prev_st = state;
    end

    task automatic push_exp(input vec_t e, input int nk);
        for (int n = 0; n < NB; n++)
            sb.push_back('{chk: (n < nk), val: e[n]});
    endtask

    task automatic wait_done();
        int c = 0;
        while (done !== 1'b1 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("idle_at_done", {29'd0, state}, 32'd0);
        @(negedge clk);
`ifdef RC4_DONE_HOLD_EN
        chk("done_hold", {31'd0, done}, 32'd1);
`else
        chk("done_pulse", {31'd0, done}, 32'd0);
`endif
    endtask

    task automatic run(input logic [31:0] k, input logic [7:0] l,
                       input vec_t e, input int nk);
        @(negedge clk);
        key = k;
        key_length = l;
        start = 1'b1;
        push_exp(e, nk);
        @(negedge clk);
        start = 1'b0;
        chk("init_entry", {29'd0, state}, 32'd1);
        chk("done_clr", {31'd0, done}, 32'd0);
        wait_done();
    endtask

    initial begin
        int n_init, n_ksa, n_prga, flag_err, c;
        repeat (3) @(negedge clk);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ckey", {24'd0, ckey}, 32'd0);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_ij", {16'd0, i_out, j_out}, 32'd0);
        chk("rst_addr", {raddr_1, waddr_2, addr_3, wdata_3}, 32'd0);
        rst = 1'b0;

        run(32'h0079654B, 8'd3, key_exp, NB);
        repeat (3) @(negedge clk);
        chk("ckey_hold", {24'd0, ckey}, 32'h19);
        chk("idle_outs", {raddr_1, rdata_1, addr_3, rdata_3}, 32'd0);

        run(32'h696B6957, 8'd4, wiki_exp, 6);
        run(32'h696B6957, 8'd0, wiki_exp, 6);
        run(32'h696B6957, 8'd7, wiki_exp, 6);

        // start held high for the whole run
        @(negedge clk);
        key = 32'h64636261;
        key_length = 8'd4;
        start = 1'b1;
        push_exp(none_exp, 0);
        n_init = 0;
        n_ksa = 0;
        n_prga = 0;
        flag_err = 0;
        c = 0;
        @(negedge clk);
        while (done !== 1'b1 && c < 5000) begin
            if (state == 3'd1) n_init++;
            if (state >= 3'd2 && state <= 3'd4) n_ksa++;
            if (state >= 3'd5) n_prga++;
            if (KSA !== (state >= 3'd2 && state <= 3'd4)) flag_err++;
            if (PRGA !== (state >= 3'd5)) flag_err++;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("held_done", {31'd0, done}, 32'd1);
        chk("init_cycles", n_init, 256);
        chk("ksa_cycles", n_ksa, 768);
        chk("prga_cycles", n_prga, 3 * NB);
        chk("phase_flags", flag_err, 0);
        @(negedge clk);
        chk("no_restart", {29'd0, state}, 32'd0);

        // reset in the middle of KSA, then a fresh run with another key
        @(negedge clk);
        key = 32'h696B6957;
        key_length = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (state !== 3'd3 && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk("reached_ksa", {29'd0, state}, 32'd3);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ckey", {24'd0, ckey}, 32'd0);
        chk("midrst_wen", {31'd0, wen}, 32'd0);
        chk("midrst_ij", {16'd0, i_out, j_out}, 32'd0);
        rst = 1'b0;
        run(32'h0079654B, 8'd3, key_exp, NB);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rc4.md
RC4 -- requirements
Module: rc4

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16: keystream bytes produced per run (1..255).
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: run request, sampled only in IDLE.
REQ-005 SHALL have port key, input, 32: key bytes, little-endian; byte n = key[8n+7:8n].
REQ-006 SHALL have port key_length, input, 8: key length in bytes; 0 or >4 treated as 4.
REQ-007 SHALL have port state, output, 3: FSM state encoding.
REQ-008 SHALL have ports KSA and PRGA, output, 1 each: high while in KSA states / PRGA states respectively.
REQ-009 SHALL have port wen, output, 1: S-box write enable.
REQ-010 SHALL have ports i_out, j_out, output, 8 each: current i and j registers.
REQ-011 SHALL have port k_out, output, 8: current output index t = S[i]+S[j].
REQ-012 SHALL have ports raddr_1/rdata_1, output, 8 each: S-box read port 1 address and its combinational data.
REQ-013 SHALL have ports waddr_2/wdata_2, output, 8 each: S-box write port 2.
REQ-014 SHALL have ports addr_3/rdata_3/wdata_3, output, 8 each: S-box port 3 read/write address, read data, write data.
REQ-015 SHALL have port ckey, output, 8: last keystream byte.
REQ-016 SHALL have port done, output, 1: run complete.

Function
REQ-017 SHALL hold an internal 256x8 S-box with combinational reads and writes on the clock edge when wen=1.
REQ-018 SHALL use states IDLE=0, INIT=1, KSA_A=2, KSA_B=3, KSA_C=4, PRGA_A=5, PRGA_B=6, PRGA_C=7.
REQ-019 IDLE: on start=1, SHALL latch key/key_length, clear i, j, and go to INIT; otherwise remain.
REQ-020 INIT: SHALL write S[i]=i through port 2 (wen=1), one entry per cycle, i wrapping 255->0, then go to KSA_A (256 cycles).
REQ-021 KSA_A: SHALL drive raddr_1=i, register si=S[i] and j=j+si+keybyte[i mod len] (mod 256).
REQ-022 KSA_B: SHALL drive addr_3=j, register sj=rdata_3.
REQ-023 KSA_C: SHALL assert wen, write S[i]=sj (port 2) and S[j]=si (port 3); i==j SHALL leave S unchanged; i++; after i=255 clear i, j and go to PRGA_A, else KSA_A.
REQ-024 PRGA_A: SHALL set i=i+1, drive raddr_1=i+1, register si, set j=j+si.
REQ-025 PRGA_B: SHALL read sj=S[j] via addr_3.
REQ-026 PRGA_C: SHALL swap as in KSA_C, set k_out=t=si+sj, read S[t] via raddr_1 with bypass (t==i gives sj, t==j gives si), register result to ckey.
REQ-027 After NUM_BYTES bytes SHALL go to IDLE and assert done; else PRGA_A. Each byte takes 3 cycles; ckey valid from the cycle after PRGA_C.
REQ-028 start SHALL be ignored outside IDLE; ckey SHALL hold its value in IDLE.
REQ-029 When idle, address/data outputs SHALL be 0 and wen SHALL be 0.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, clear i, j, k_out, ckey, done, wen and all address/data outputs, including mid-run; S-box contents need not be cleared.

Configuration
REQ-031 Macro RC4_DONE_HOLD_EN defined: done SHALL stay high from completion until the next accepted start or reset. Undefined: done SHALL be a single-cycle pulse on the cycle after the last PRGA_C.

Verification
REQ-032 key=32'h0079654B ("Key"), len=3, start -> ckey sequence EB 9F 77 81 B7 34 CA 72 A7 19.
REQ-033 key=32'h696B6957 ("Wiki"), len=4 -> ckey 60 44 DB 6D 41 B7.
REQ-034 key=32'h64636261, len=4, start held high -> INIT 256 cycles, KSA 768 cycles, first byte 3 cycles later; one run only until done.
REQ-035 rst asserted during KSA -> state=0, done=0 next cycle; new start rereads key and reproduces REQ-032 output.
REQ-036 len=0 with "Wiki" key -> output identical to REQ-033.
REQ-037 Both macro settings -> done width 1 cycle vs held until next start.
